// File: rtl/busarb_if.sv
// AHB-Lite-like bus bundle shared by the arbiter's master ports and its slave port.
// The master modport issues the address/data phase; the slave modport returns the response.
interface busarb_if;
    logic [31:0] haddr;
    logic        hprot;
    logic [1:0]  hsize;
    logic        hwrite;
    logic [31:0] hwdata;
    logic        htrans;
    logic [31:0] hrdata;
    logic        hresp;
    logic        hready;

    modport master (
        output haddr, hprot, hsize, hwrite, hwdata, htrans,
        input  hrdata, hresp, hready
    );

    modport slave (
        input  haddr, hprot, hsize, hwrite, hwdata, htrans,
        output hrdata, hresp, hready
    );
endinterface

// File: rtl/busarb.sv
// Two-master (data d / instruction i) arbiter for the single system bus, with a
// one-entry address hold buffer per master and data-phase response routing.
module busarb #(
    parameter bit RR = 1'b1
) (
    input  logic      clk,
    input  logic      rstn,
    busarb_if.slave   d_bus,
    busarb_if.slave   i_bus,
    busarb_if.master  s_bus
);

    typedef enum logic [1:0] {OWN_NONE, OWN_D, OWN_I} owner_e;
    typedef enum logic       {M_D, M_I} master_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        prot;
        logic [1:0]  size;
        logic        write;
    } aph_t;

    owner_e  r_dp_owner;
    master_e r_last_gnt;
    logic    r_hold_v_d, r_hold_v_i;
    aph_t    r_hold_d, r_hold_i;

    owner_e  w_gnt;
    aph_t    w_d_live, w_i_live, w_aph;
    logic    w_htrans;
    logic    w_d_ready, w_i_ready;
    logic    w_cap_d, w_cap_i;
    logic    w_accept;

    assign w_d_live = '{addr: d_bus.haddr, prot: d_bus.hprot, size: d_bus.hsize, write: d_bus.hwrite};
    assign w_i_live = '{addr: i_bus.haddr, prot: i_bus.hprot, size: i_bus.hsize, write: i_bus.hwrite};

    // A held entry always wins; live ties go round-robin or to d.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_gnt = OWN_NONE;
        if (r_hold_v_d)
            w_gnt = OWN_D;
        else if (r_hold_v_i)
            w_gnt = OWN_I;
        else if (d_bus.htrans && i_bus.htrans)
            w_gnt = (RR && r_last_gnt == M_D) ? OWN_I : OWN_D;
        else if (d_bus.htrans)
            w_gnt = OWN_D;
        else if (i_bus.htrans)
            w_gnt = OWN_I;
    end

    always_comb begin
        w_aph    = '0;
        w_htrans = 1'b0;
        case (w_gnt)
            OWN_D: begin
                w_aph    = r_hold_v_d ? r_hold_d : w_d_live;
                w_htrans = 1'b1;
            end
            OWN_I: begin
                w_aph    = r_hold_v_i ? r_hold_i : w_i_live;
                w_htrans = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_d_ready = 1'b1;
        if (r_hold_v_d)
            w_d_ready = 1'b0;
        else if (r_dp_owner == OWN_D || w_gnt == OWN_D)
            w_d_ready = s_bus.hready;
        else if (d_bus.htrans)
            w_d_ready = 1'b0;

        w_i_ready = 1'b1;
        if (r_hold_v_i)
            w_i_ready = 1'b0;
        else if (r_dp_owner == OWN_I || w_gnt == OWN_I)
            w_i_ready = s_bus.hready;
        else if (i_bus.htrans)
            w_i_ready = 1'b0;
    end

    // A master whose data phase completes while the other owns the grant has
    // had its next address acknowledged; park it until it can be issued.
    assign w_cap_d  = w_d_ready && d_bus.htrans && (w_gnt != OWN_D);
    assign w_cap_i  = w_i_ready && i_bus.htrans && (w_gnt != OWN_I);
    assign w_accept = s_bus.hready && w_htrans;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_dp_owner <= OWN_NONE;
            r_last_gnt <= M_I;
            r_hold_v_d <= 1'b0;
            r_hold_v_i <= 1'b0;
            r_hold_d   <= '0;
            r_hold_i   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            if (w_accept) begin
                r_dp_owner <= w_gnt;
                r_last_gnt <= (w_gnt == OWN_I) ? M_I : M_D;
                if (w_gnt == OWN_D)
                    r_hold_v_d <= 1'b0;
                if (w_gnt == OWN_I)
                    r_hold_v_i <= 1'b0;
            end else if (s_bus.hready) begin
                r_dp_owner <= OWN_NONE;
            end

            if (w_cap_d) begin
                r_hold_v_d <= 1'b1;
                r_hold_d   <= w_d_live;
            end
            if (w_cap_i) begin
                r_hold_v_i <= 1'b1;
                r_hold_i   <= w_i_live;
            end
        end
    end

    assign s_bus.haddr  = w_aph.addr;
    assign s_bus.hprot  = w_aph.prot;
    assign s_bus.hsize  = w_aph.size;
    assign s_bus.hwrite = w_aph.write;
    assign s_bus.htrans = w_htrans;

    always_comb begin
        s_bus.hwdata = '0;
        case (r_dp_owner)
            OWN_D:   s_bus.hwdata = d_bus.hwdata;
            OWN_I:   s_bus.hwdata = i_bus.hwdata;
            default: ;
        endcase
    end

    assign d_bus.hrdata = s_bus.hrdata;
    assign i_bus.hrdata = s_bus.hrdata;
    assign d_bus.hresp  = s_bus.hresp && (r_dp_owner == OWN_D);
    assign i_bus.hresp  = s_bus.hresp && (r_dp_owner == OWN_I);
    assign d_bus.hready = w_d_ready;
    assign i_bus.hready = w_i_ready;

endmodule

// File: tb/tb_busarb.sv
// Directed bench for busarb: a round-robin instance (main) and a fixed-priority
// instance fed the same stimulus, checked with immediate assertions.
module tb_busarb;

    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    busarb_if d_if ();
    busarb_if i_if ();
    busarb_if s_if ();
    busarb_if d2_if ();
    busarb_if i2_if ();
    busarb_if s2_if ();

    busarb #(.RR(1'b1)) dut (
        .clk   (clk),
        .rstn  (rstn),
        .d_bus (d_if),
        .i_bus (i_if),
        .s_bus (s_if)
    );

    busarb #(.RR(1'b0)) dut_fp (
        .clk   (clk),
        .rstn  (rstn),
        .d_bus (d2_if),
        .i_bus (i2_if),
        .s_bus (s2_if)
    );

    assign d2_if.haddr  = d_if.haddr;
    assign d2_if.hprot  = d_if.hprot;
    assign d2_if.hsize  = d_if.hsize;
    assign d2_if.hwrite = d_if.hwrite;
    assign d2_if.hwdata = d_if.hwdata;
    assign d2_if.htrans = d_if.htrans;
    assign i2_if.haddr  = i_if.haddr;
    assign i2_if.hprot  = i_if.hprot;
    assign i2_if.hsize  = i_if.hsize;
    assign i2_if.hwrite = i_if.hwrite;
    assign i2_if.hwdata = i_if.hwdata;
    assign i2_if.htrans = i_if.htrans;
    assign s2_if.hrdata = s_if.hrdata;
    assign s2_if.hresp  = s_if.hresp;
    assign s2_if.hready = s_if.hready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        @(negedge clk);
        tick();
        rstn = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rstn   = 1'b0;
        d_if.haddr = '0; d_if.hprot = 1'b0; d_if.hsize = '0; d_if.hwrite = 1'b0;
        d_if.hwdata = '0; d_if.htrans = 1'b0;
        i_if.haddr = '0; i_if.hprot = 1'b0; i_if.hsize = '0; i_if.hwrite = 1'b0;
        i_if.hwdata = '0; i_if.htrans = 1'b0;
        s_if.hrdata = '0; s_if.hresp = 1'b0; s_if.hready = 1'b1;

        // Reset and idle
        @(negedge clk);
        check("rst_htrans",  32'(s_if.htrans), 32'd0);
        check("rst_haddr",   s_if.haddr,       32'd0);
        check("rst_d_hready", 32'(d_if.hready), 32'd1);
        check("rst_i_hready", 32'(i_if.hready), 32'd1);
        check("rst_hwdata",  s_if.hwdata,      32'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        check("idle_htrans", 32'(s_if.htrans), 32'd0);
        check("idle_d_hresp", 32'(d_if.hresp), 32'd0);
        tick();

        // Single d read, zero-latency address then data phase
        d_if.htrans = 1'b1; d_if.haddr = 32'h2000_0010; d_if.hsize = 2'b10; d_if.hprot = 1'b1;
        @(negedge clk);
        check("rd_htrans",   32'(s_if.htrans), 32'd1);
        check("rd_haddr",    s_if.haddr,       32'h2000_0010);
        check("rd_hsize",    32'(s_if.hsize),  32'd2);
        check("rd_hprot",    32'(s_if.hprot),  32'd1);
        check("rd_d_hready", 32'(d_if.hready), 32'd1);
        tick();
        d_if.htrans = 1'b0; d_if.haddr = '0; d_if.hsize = '0; d_if.hprot = 1'b0;
        s_if.hrdata = 32'h0000_1234;
        @(negedge clk);
        check("rd_d_hrdata", d_if.hrdata,      32'h0000_1234);
        check("rd_i_hrdata", i_if.hrdata,      32'h0000_1234);
        check("rd_dp_d_hready", 32'(d_if.hready), 32'd1);
        check("rd_d_hresp",  32'(d_if.hresp),  32'd0);
        check("rd_i_hresp",  32'(i_if.hresp),  32'd0);
        check("rd_dp_htrans", 32'(s_if.htrans), 32'd0);
        tick();
        s_if.hrdata = '0;

        // i write address, then its data phase under 3 wait states with d pending
        i_if.htrans = 1'b1; i_if.haddr = 32'h0000_0300; i_if.hwrite = 1'b1;
        @(negedge clk);
        check("wr_haddr",  s_if.haddr,       32'h0000_0300);
        check("wr_hwrite", 32'(s_if.hwrite), 32'd1);
        tick();
        i_if.htrans = 1'b0; i_if.haddr = '0; i_if.hwrite = 1'b0; i_if.hwdata = 32'h0000_55AA;
        d_if.htrans = 1'b1; d_if.haddr = 32'h2000_0040;
        s_if.hready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("ws%0d_hwdata", k),   s_if.hwdata,      32'h0000_55AA);
            check($sformatf("ws%0d_i_hready", k), 32'(i_if.hready), 32'd0);
            check($sformatf("ws%0d_d_hready", k), 32'(d_if.hready), 32'd0);
            check($sformatf("ws%0d_haddr", k),    s_if.haddr,       32'h2000_0040);
            tick();
        end
        s_if.hready = 1'b1;
        @(negedge clk);
        check("ws_end_i_hready", 32'(i_if.hready), 32'd1);
        check("ws_end_d_hready", 32'(d_if.hready), 32'd1);
        check("ws_end_hwdata",   s_if.hwdata,      32'h0000_55AA);
        tick();

        // Error response in d's data phase
        d_if.htrans = 1'b0; d_if.haddr = '0; d_if.hwdata = 32'h0000_D00D; i_if.hwdata = '0;
        s_if.hresp = 1'b1;
        @(negedge clk);
        check("err_d_hresp", 32'(d_if.hresp), 32'd1);
        check("err_i_hresp", 32'(i_if.hresp), 32'd0);
        check("err_hwdata",  s_if.hwdata,     32'h0000_D00D);
        tick();
        s_if.hresp = 1'b0; d_if.hwdata = '0;

        // Contention and hold path; dut_fp shows d-over-i priority on the same stimulus
        do_reset();
        d_if.htrans = 1'b1; d_if.haddr = 32'h2000_0018;
        i_if.htrans = 1'b1; i_if.haddr = 32'h0000_0400;
        @(negedge clk);
        check("c1_haddr",      s_if.haddr,        32'h2000_0018);
        check("c1_i_hready",   32'(i_if.hready),  32'd0);
        check("c1_d_hready",   32'(d_if.hready),  32'd1);
        check("fp_c1_haddr",   s2_if.haddr,       32'h2000_0018);
        check("fp_c1_i_hready", 32'(i2_if.hready), 32'd0);
        tick();
        d_if.haddr = 32'h2000_0020;
        @(negedge clk);
        check("c2_haddr",      s_if.haddr,        32'h0000_0400);
        check("c2_i_hready",   32'(i_if.hready),  32'd1);
        check("c2_d_hready",   32'(d_if.hready),  32'd1);
        check("fp_c2_haddr",   s2_if.haddr,       32'h2000_0020);
        check("fp_c2_i_hready", 32'(i2_if.hready), 32'd0);
        tick();
        d_if.haddr = 32'h2000_0030;
        i_if.haddr = 32'h0000_0404;
        @(negedge clk);
        check("hold_haddr",    s_if.haddr,        32'h2000_0020);
        check("hold_htrans",   32'(s_if.htrans),  32'd1);
        check("hold_d_hready", 32'(d_if.hready),  32'd0);
        check("hold_i_hready", 32'(i_if.hready),  32'd1);
        check("fp_c3_haddr",   s2_if.haddr,       32'h2000_0030);
        check("fp_c3_i_hready", 32'(i2_if.hready), 32'd0);
        tick();
        s_if.hready = 1'b0;
        @(negedge clk);
        check("hold_ws_haddr",    s_if.haddr,       32'h0000_0404);
        check("hold_ws_d_hready", 32'(d_if.hready), 32'd0);
        check("hold_ws_i_hready", 32'(i_if.hready), 32'd0);
        tick();
        s_if.hready = 1'b1;
        @(negedge clk);
        check("hold_done_d_hready", 32'(d_if.hready), 32'd1);
        check("hold_done_haddr",    s_if.haddr,       32'h0000_0404);
        tick();
        d_if.htrans = 1'b0; i_if.htrans = 1'b0;
        @(negedge clk);
        check("hold2_haddr",    s_if.haddr,       32'h2000_0030);
        check("hold2_d_hready", 32'(d_if.hready), 32'd0);

        // Asynchronous reset while d holds an entry
        rstn = 1'b0;
        #1;
        check("arst_htrans",   32'(s_if.htrans), 32'd0);
        check("arst_haddr",    s_if.haddr,       32'd0);
        check("arst_d_hready", 32'(d_if.hready), 32'd1);
        tick();
        rstn = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/busarb.md
# busarb

Two-master arbiter for the single AHB-Lite-like system bus in the MCU core. It shares the bus between the data-access master (d_) and the instruction-fetch master (i_). It pipelines address and data phases across masters and routes each data-phase response back to the master that owns it. Each master port carries the same signal set as the slave port, plus a per-master hready. A one-entry hold buffer per master resolves the case where a master's data phase completes while its next address loses arbitration.

## Interface
- RR, default 1: 1 = round-robin between live requests; 0 = fixed priority, d over i.
- clk  in  1  system clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- d_haddr, i_haddr  in  32  master address
- d_hprot, i_hprot  in  1  data/instruction indicator
- d_hsize, i_hsize  in  2  transfer size
- d_hwrite, i_hwrite  in  1  write
- d_hwdata, i_hwdata  in  32  write data (master's data phase)
- d_htrans, i_htrans  in  1  transfer request
- d_hrdata, i_hrdata  out  32  read data (copy of hrdata)
- d_hresp, i_hresp  out  1  error response, owner-gated
- d_hready, i_hready  out  1  per-master ready
- haddr, hprot, hsize, hwrite, htrans  out  32/1/2/1/1  slave address phase
- hwdata  out  32  slave write data
- hrdata, hresp, hready  in  32/1/1  slave response

## Operation
- State registers:
  - hold_v/hold_{addr,prot,size,write}, one set per master.
  - dp_owner ∈ {NONE, D, I}.
  - last_gnt ∈ {D, I}, used when RR=1.
- Candidates: a held master (hold_v_X) or a live master (X_htrans & !hold_v_X).
- Grant (combinational, independent of hready):
  - A held master beats any live master.
  - Two live masters: RR=1 grants the master ≠ last_gnt; RR=0 grants d.
  - Both masters held at once cannot occur.
- Address phase: the granted source (hold regs or live inputs) drives haddr/hprot/hsize/hwrite, with htrans=1. With no grant, all address-phase outputs are 0.
- Acceptance: hready & htrans.
  - dp_owner <= granted master; last_gnt <= granted master.
  - A granted held entry clears its hold_v_X.
  - With hready & !htrans, dp_owner <= NONE.
- hX_ready (X_hready), in priority order:
  1. hold_v_X: 0.
  2. Else dp_owner==X or X granted live: equals hready.
  3. Else X_htrans: 0 (stall).
  4. Else: 1 (idle).
- Hold capture: X_hready=1 & X_htrans & X not granted. This only occurs when X's data phase completes while the other master holds the grant. On capture, hold regs <= live X address fields and hold_v_X <= 1. From then the master's data phase is stalled until the held transfer's bus data phase completes.
- Data mux by dp_owner:
  - D: hwdata = d_hwdata; I: hwdata = i_hwdata; NONE: hwdata = 0.
  - X_hresp = hresp & (dp_owner==X).
  - Both X_hrdata = hrdata.

## Timing
- Reset values:
  - Registers: hold_v 0, dp_owner NONE, last_gnt I (so d wins the first tie).
  - Outputs: htrans 0, haddr/hprot/hsize/hwrite/hwdata 0, d_hready = i_hready = 1, hresp_X 0.
- Granted live request: zero added latency; the address appears on the bus in the same cycle as X_htrans.
- Held request: issued no earlier than the cycle after capture.
- The losing master's X_hready stays low and its address is not sampled until the cycle it is granted.
- Wait states (hready=0):
  - Bus address, grant and dp_owner are frozen, as long as the inputs are stable.
  - hwdata follows dp_owner.
  - The owner's X_hready is 0.
- An address must not change while X_htrans=1 & X_hready=0. The block does not check this.
- Reset asserted mid-transfer clears hold and dp_owner immediately (asynchronously). Any in-flight transfer is abandoned with no response.

## Test plan
- Reset/idle: hold rstn low, then release with all htrans=0 → htrans=0, haddr=0, d_hready=i_hready=1, hwdata=0.
- Single read:
  - Cycle 1: d_htrans=1, d_haddr=0x20000010, hready=1 → htrans=1, haddr=0x20000010, d_hready=1 in the same cycle.
  - Cycle 2: hrdata=0x00001234, hready=1 → d_hrdata=0x1234, d_hready=1, d_hresp=0, i_hresp=0.
- Contention, RR=1, after reset: d_htrans and i_htrans both 1 with hready=1 → cycle 1 haddr=d address, i_hready=0; cycle 2 haddr=i address, i_hready=1. Repeat with RR=0 and d requesting continuously → i is never granted.
- Hold path:
  - Setup: d owns the data phase and presents a new address 0x20000020; i is granted (last_gnt=D); hready=1.
  - Required: d_hready=1 and the d address is captured.
  - Next cycle: haddr=0x20000020 and d_hready=0, until that transfer's data phase sees hready=1.
- Wait states: i write of 0x55AA in its data phase with hready=0 for 3 cycles → hwdata=0x55AA throughout, i_hready=0, and a pending d address held stable on haddr.
- Error and reset: hresp=1 with hready=1 in d's data phase → d_hresp=1, i_hresp=0. Then assert rstn low while hold_v_d=1 → hold cleared, htrans=0 immediately.
